// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single memory port between fetch and data, one transaction outstanding.
// Define MEM_ARB_FAIR_EN to bound consecutive data grants while fetch is pending.
module mem_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int STREAK_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [DATA_W/8-1:0] d_be,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W/8-1:0] mem_be,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);
   typedef enum logic [1:0] {IDLE, ADDR, WAIT} state_t;
   state_t state, state_n;
   logic owner, owner_n;
   logic fair_turn, any_req, pick_d, sel_d, accept, rsp;
   assign any_req = if_req | d_req;
   assign pick_d = d_req & ~(if_req & fair_turn);
   // once past IDLE the locked owner drives the port regardless of the other requester
   assign sel_d = (state == IDLE) ? pick_d : owner;
   assign mem_req = rst_n & ((state == IDLE) ? any_req : (state == ADDR));
   assign accept = mem_req & mem_gnt;
   assign if_gnt = accept & ~sel_d;
   assign d_gnt = accept & sel_d;
   assign mem_we = rst_n & sel_d & d_we;
   assign mem_be = !rst_n ? '0 : sel_d ? d_be : '1;
   assign mem_addr = !rst_n ? '0 : sel_d ? d_addr : if_addr;
   assign mem_wdata = (rst_n & sel_d) ? d_wdata : '0;
   assign rsp = rst_n & (state == WAIT) & mem_rvalid;
   assign if_rvalid = rsp & ~owner;
   assign d_rvalid = rsp & owner;
   assign if_rdata = if_rvalid ? mem_rdata : '0;
   assign d_rdata = d_rvalid ? mem_rdata : '0;
   assign busy = rst_n & (state != IDLE);
   always_comb begin
      state_n = state;
      owner_n = owner;
      if (state == IDLE && any_req) begin
         state_n = mem_gnt ? WAIT : ADDR;
         owner_n = pick_d;
      end else if (state == ADDR && mem_gnt) state_n = WAIT;
      else if (state == WAIT && mem_rvalid) state_n = IDLE;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         owner <= 1'b0;
      end else begin
         state <= state_n;
         owner <= owner_n;
      end
`ifdef MEM_ARB_FAIR_EN
   localparam int SW = $clog2(STREAK_MAX + 1);
   localparam logic [SW-1:0] SMAX = SW'(STREAK_MAX);
   logic [SW-1:0] streak;
   assign fair_turn = streak == SMAX;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) streak <= '0;
      else if (if_gnt || (state == IDLE && !if_req)) streak <= '0;
      else if (d_gnt && if_req && streak != SMAX) streak <= streak + SW'(1);
`else
   assign fair_turn = STREAK_MAX < 0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, directed corner sequences and a randomized transaction-level model.
module tb_mem_port_arbiter;
`ifdef MEM_ARB_FAIR_EN
   localparam bit FAIR = 1'b1;
`else
   localparam bit FAIR = 1'b0;
`endif
   localparam int SMAX = 4;
   logic clk = 1'b0, rst_n = 1'b0;
   logic if_req = 0, if_gnt, if_rvalid;
   logic [31:0] if_addr = 0, if_rdata;
   logic d_req = 0, d_we = 0, d_gnt, d_rvalid;
   logic [3:0] d_be = 0;
   logic [31:0] d_addr = 0, d_wdata = 0, d_rdata;
   logic mem_req, mem_we, mem_gnt = 0, mem_rvalid = 0;
   logic [3:0] mem_be;
   logic [31:0] mem_addr, mem_wdata, mem_rdata = 0;
   logic busy;
   int checks = 0, failures = 0;

   mem_port_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic ir, dr, we, g;
      logic er, eig, edg, ewe;
      logic [31:0] ea;
   } vec_t;
   vec_t vecs[7];

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h @%0t", n, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 0; if_req = 0; d_req = 0; d_we = 0; mem_gnt = 0; mem_rvalid = 0;
      step();
      rst_n = 1;
   endtask

   int phase, streak;
   bit own_d, wd, e_mreq, e_ig, e_dg, e_irv, e_drv;

   initial begin
      vecs[0] = '{0, 0, 0, 1, 0, 0, 0, 0, 32'h0};
      vecs[1] = '{1, 0, 0, 1, 1, 1, 0, 0, 32'h40};
      vecs[2] = '{0, 1, 0, 1, 1, 0, 1, 0, 32'h200};
      vecs[3] = '{0, 1, 1, 0, 1, 0, 0, 1, 32'h200};
      vecs[4] = '{1, 1, 0, 1, 1, 0, 1, 0, 32'h200};
      vecs[5] = '{1, 1, 1, 0, 1, 0, 0, 1, 32'h200};
      vecs[6] = '{1, 0, 1, 1, 1, 1, 0, 0, 32'h40};
      for (int i = 0; i < 7; i++) begin
         apply_reset();
         if_addr = 32'h40; d_addr = 32'h200; d_be = 4'h5;
         if_req = vecs[i].ir; d_req = vecs[i].dr; d_we = vecs[i].we; mem_gnt = vecs[i].g;
         #1;
         chk("vec_mem_req", mem_req, vecs[i].er);
         chk("vec_if_gnt", if_gnt, vecs[i].eig);
         chk("vec_d_gnt", d_gnt, vecs[i].edg);
         chk("vec_mem_we", mem_we, vecs[i].ewe);
         if (vecs[i].er) chk("vec_mem_addr", mem_addr, vecs[i].ea);
      end

      // reset while waiting for a load response
      apply_reset();
      d_req = 1; d_we = 0; d_addr = 32'h100; mem_gnt = 1; #1;
      chk("rst_d_gnt", d_gnt, 1);
      step(); d_req = 0; #1;
      chk("rst_busy_wait", busy, 1);
      rst_n = 0; if_req = 1; d_req = 1; mem_rvalid = 1; #1;
      chk("rst_mem_req", mem_req, 0);
      chk("rst_gnts", {if_gnt, d_gnt}, 0);
      chk("rst_rvalids", {if_rvalid, d_rvalid}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_fields", {mem_we, mem_be, mem_addr}, 0);
      step(); rst_n = 1; if_req = 0; d_req = 0; mem_rvalid = 1; #1;
      chk("rst_late_rvalid", d_rvalid, 0);
      chk("rst_idle", busy, 0);
      step(); mem_rvalid = 0;

      // single fetch with mem_gnt held high
      if_req = 1; if_addr = 32'h40; mem_gnt = 1; #1;
      chk("f_gnt", if_gnt, 1);
      chk("f_we", mem_we, 0);
      chk("f_be", mem_be, 4'hF);
      chk("f_addr", mem_addr, 32'h40);
      step(); if_req = 0; #1;
      chk("f_no_early_rvalid", if_rvalid, 0);
      chk("f_busy", busy, 1);
      step(); mem_rvalid = 1; mem_rdata = 32'hDEADBEEF; #1;
      chk("f_rvalid", if_rvalid, 1);
      chk("f_rdata", if_rdata, 32'hDEADBEEF);
      step(); mem_rvalid = 0; #1;
      chk("f_rvalid_off", if_rvalid, 0);
      chk("f_rdata_zero", if_rdata, 0);
      chk("f_idle", busy, 0);

      // store through the data port
      d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h200; d_wdata = 32'h1234; #1;
      chk("s_fields", {mem_req, mem_we, mem_be, mem_addr}, {1'b1, 1'b1, 4'b0011, 32'h200});
      chk("s_wdata", mem_wdata, 32'h1234);
      chk("s_gnt", d_gnt, 1);
      step(); d_req = 0; d_we = 0; mem_rvalid = 1; #1;
      chk("s_rvalid", d_rvalid, 1);
      chk("s_no_if_rvalid", if_rvalid, 0);
      step(); mem_rvalid = 0;

      // contention with a slow memory grant
      mem_gnt = 0; if_req = 1; if_addr = 32'h40; d_req = 1; d_addr = 32'h300; #1;
      chk("c_addr0", mem_addr, 32'h300);
      chk("c_gnt0", {if_gnt, d_gnt}, 0);
      for (int k = 1; k < 3; k++) begin
         step(); if_addr = 32'h80; #1;
         chk("c_hold_addr", mem_addr, 32'h300);
         chk("c_hold_req", mem_req, 1);
         chk("c_hold_gnt", {if_gnt, d_gnt}, 0);
      end
      step(); mem_gnt = 1; #1;
      chk("c_dgnt", {if_gnt, d_gnt}, 2'b01);
      chk("c_dgnt_addr", mem_addr, 32'h300);
      step(); d_req = 0; #1;
      chk("c_wait_noreq", mem_req, 0);
      mem_rvalid = 1; #1;
      chk("c_drvalid", d_rvalid, 1);
      step(); mem_rvalid = 0; #1;
      chk("c_fetch_next", if_gnt, 1);
      chk("c_fetch_addr", mem_addr, 32'h80);
      step(); if_req = 0; mem_rvalid = 1; #1;
      chk("c_fetch_rvalid", if_rvalid, 1);
      step(); mem_rvalid = 0;

      // both requesters continuously active
      apply_reset();
      if_req = 1; d_req = 1; d_we = 0; mem_gnt = 1;
      for (int k = 0; k < 10; k++) begin
         #1;
         chk("fair_grant", {if_gnt, d_gnt}, (FAIR && k % 5 == 4) ? 2'b10 : 2'b01);
         step(); mem_rvalid = 1;
         step(); mem_rvalid = 0;
      end

      // spurious responses in IDLE and ADDR
      apply_reset();
      mem_rvalid = 1; #1;
      chk("sp_idle_rv", {if_rvalid, d_rvalid}, 0);
      chk("sp_idle_busy", busy, 0);
      step(); #1;
      chk("sp_idle_stay", busy, 0);
      mem_rvalid = 0; mem_gnt = 0; d_req = 1; d_addr = 32'h500;
      step(); mem_rvalid = 1; #1;
      chk("sp_addr_rv", d_rvalid, 0);
      step(); mem_rvalid = 0; #1;
      chk("sp_addr_stay", {busy, mem_req}, 2'b11);
      mem_gnt = 1; #1;
      chk("sp_addr_gnt", d_gnt, 1);
      step(); d_req = 0; mem_rvalid = 1; #1;
      chk("sp_rv", d_rvalid, 1);
      step(); mem_rvalid = 0;

      // randomized traffic against a transaction-level model
      apply_reset();
      phase = 0; streak = 0; own_d = 0;
      for (int c = 0; c < 500; c++) begin
         if (!if_req && $urandom_range(0, 2) == 0) begin
            if_req = 1; if_addr = $urandom;
         end
         if (!d_req && $urandom_range(0, 2) == 0) begin
            d_req = 1; d_we = $urandom_range(0, 1); d_be = 4'($urandom); d_addr = $urandom; d_wdata = $urandom;
         end
         mem_gnt = $urandom_range(0, 1);
         mem_rvalid = $urandom_range(0, 2) == 0;
         mem_rdata = $urandom;
         #1;
         e_ig = 0; e_dg = 0; e_irv = 0; e_drv = 0; wd = own_d;
         if (phase == 0) begin
            e_mreq = if_req | d_req;
            wd = d_req && !(if_req && FAIR && streak == SMAX);
         end else e_mreq = (phase == 1);
         if (e_mreq && mem_gnt) begin
            e_dg = wd; e_ig = !wd;
         end
         if (phase == 2) begin
            e_irv = mem_rvalid && !own_d; e_drv = mem_rvalid && own_d;
         end
         chk("r_mem_req", mem_req, e_mreq);
         chk("r_gnt", {if_gnt, d_gnt}, {e_ig, e_dg});
         chk("r_rvalid", {if_rvalid, d_rvalid}, {e_irv, e_drv});
         chk("r_if_rdata", if_rdata, e_irv ? mem_rdata : 32'h0);
         chk("r_d_rdata", d_rdata, e_drv ? mem_rdata : 32'h0);
         chk("r_busy", busy, phase != 0);
         if (e_mreq) begin
            chk("r_mem_addr", mem_addr, wd ? d_addr : if_addr);
            chk("r_mem_we", mem_we, wd && d_we);
            chk("r_mem_be", mem_be, wd ? d_be : 4'hF);
         end
         if (e_ig || (phase == 0 && !if_req)) streak = 0;
         else if (e_dg && if_req && streak < SMAX) streak++;
         if (phase == 0 && e_mreq) begin
            own_d = wd; phase = mem_gnt ? 2 : 1;
         end else if (phase == 1 && mem_gnt) phase = 2;
         else if (phase == 2 && mem_rvalid) phase = 0;
         step();
         if (e_ig) if_req = 0;
         if (e_dg) d_req = 0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the CPU's single memory port between instruction fetch and the load/store (data) path. Requests are accepted on a request/grant handshake, and each granted access stays locked until its response returns. Data accesses have priority over fetch by default, with an optional anti-starvation counter. The block sits between the fetch unit and MEM stage on one side (driven by the decoder's MemRead/MemWrite) and the memory interface on the other, with exactly one transaction outstanding.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; must be a multiple of 8
- STREAK_MAX, 4, maximum consecutive data grants while fetch is pending (range ≥1; used only with fairness enabled)
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch response valid, one cycle
- if_rdata  out  DATA_W  fetch read data; 0 when if_rvalid=0
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1=store, 0=load
- d_be  in  DATA_W/8  store byte enables
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  data response (load data or store ack), one cycle
- d_rdata  out  DATA_W  load data; 0 when d_rvalid=0
- mem_req, mem_we, mem_be, mem_addr, mem_wdata  out  1/1/DATA_W/8/ADDR_W/DATA_W  memory request and its fields
- mem_gnt  in  1  memory accepted the request
- mem_rvalid  in  1  memory response; every request, including stores, gets exactly one response
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  state ≠ IDLE

## Operation
- Internal state: IDLE, ADDR (request presented, not yet granted, owner locked), WAIT (granted, awaiting mem_rvalid). A one-bit owner register selects fetch or data.
- IDLE:
  - mem_req = if_req | d_req; combinational pick of the winner.
  - If both requesters are active, data wins. With fairness enabled, fetch wins instead when the streak counter equals STREAK_MAX.
  - The winner's fields drive mem_*.
  - For fetch: mem_we=0 and mem_be all 1s.
  - mem_gnt is passed to the winner's gnt in the same cycle. The loser's gnt is 0.
  - On request with mem_gnt=1: set owner, go to WAIT. On request with mem_gnt=0: set owner, go to ADDR.
- ADDR: mem_req=1 with the locked owner's fields, regardless of the other requester. On mem_gnt: the owner's gnt=1, go to WAIT.
- WAIT: mem_req=0. On mem_rvalid: the owner's rvalid=1 and its rdata=mem_rdata; go to IDLE. New arbitration happens in the following cycle.
- mem_rvalid in IDLE or ADDR is ignored (no rvalid output).
- A requester that drops req before gnt is a protocol violation; behaviour is undefined and need not be checked.
- Streak counter (width $clog2(STREAK_MAX+1)):
  - Increments on a data grant while if_req=1.
  - Clears on a fetch grant.
  - Clears in any IDLE cycle with if_req=0.
  - Saturates at STREAK_MAX.

## Timing
- Reset (asynchronous assert, synchronous-edge deassert):
  - State goes to IDLE, owner to fetch, streak counter to 0.
  - While rst_n=0, all outputs are 0, including mem_req (gated).
- Grant latency: 0 cycles when mem_gnt is already high in IDLE. Otherwise, the first cycle mem_gnt=1.
- Response: rvalid is asserted in the same cycle as mem_rvalid (combinational pass-through). The earliest response is 1 cycle after grant.
- Turnaround: response in cycle N gives the earliest next mem_req in cycle N+1.
- Reset during ADDR or WAIT abandons the transaction. A late mem_rvalid after reset is ignored.
- Simultaneous if_req and d_req rising in IDLE: only the winner is granted. The loser waits for the next IDLE.

## Configuration
- MEM_ARB_FAIR_EN:
  - Defined: the streak counter is present. After STREAK_MAX consecutive data grants with if_req pending, the next IDLE arbitration grants fetch.
  - Undefined: strict data priority, no counter logic, and STREAK_MAX is ignored.

## Test plan
- Reset mid-WAIT:
  - Stimulus: grant d_req load to 0x100, assert rst_n=0 before mem_rvalid, release reset, then pulse mem_rvalid.
  - Required: all outputs 0 during reset, busy=0, and no d_rvalid.
- Single fetch, mem_gnt=1 held:
  - Stimulus: if_req with if_addr=0x40; mem_rvalid 2 cycles later with 0xDEADBEEF.
  - Required: if_gnt in the same cycle, mem_we=0, mem_be=4'hF, if_rvalid=1 with if_rdata=0xDEADBEEF for one cycle.
- Store through data port:
  - Stimulus: d_we=1, d_be=4'b0011, d_addr=0x200, d_wdata=0x1234; memory acks.
  - Required: mem fields match the inputs, d_gnt then d_rvalid, if_rvalid stays 0.
- Contention with mem_gnt low 3 cycles:
  - Stimulus: if_req and d_req together.
  - Required: ADDR holds d_addr for 3 cycles even after the fetch address changes; d_gnt is asserted on the 4th cycle. After the response, fetch is granted in the next IDLE.
- Fairness (MEM_ARB_FAIR_EN, STREAK_MAX=4):
  - Stimulus: both requesters continuously active.
  - Required: grant sequence D,D,D,D,I repeating. Without the macro: all D.
- Spurious response:
  - Stimulus: mem_rvalid pulse in IDLE.
  - Required: no rvalid outputs and no state change.
